pbit_marginal_accumulator: RTL

//  Downstream consumer of the p-bit network state vector. Samples the vector once per

---
 rtl/pbit_marginal_accumulator_if.sv | 31 +++
 rtl/pbit_marginal_accumulator.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pbit_marginal_accumulator_if.sv
// Control and result-stream bundle for the p-bit marginal accumulator.
// The slave side is the accumulator; the master side is the sequencer plus the host readout.
interface pbit_marginal_accumulator_if #(
    parameter int NUM_PBITS = 9,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = (NUM_PBITS > 1) ? $clog2(NUM_PBITS) : 1
);
    logic                 start;
    logic [CNT_W-1:0]     num_samples;
    logic                 sample_stb;
    logic [NUM_PBITS-1:0] pbits;
    logic                 res_valid;
    logic                 res_ready;
    logic [CNT_W-1:0]     res_data;
    logic [IDX_W-1:0]     res_idx;
    logic                 res_last;
    logic                 busy;
    logic                 done;

    // Result stream: a word transfers on any rising edge where res_valid && res_ready.
    // Once res_valid is raised, it and res_data/res_idx/res_last hold until that transfer.
    modport slave (
        input  start, num_samples, sample_stb, pbits, res_ready,
        output res_valid, res_data, res_idx, res_last, busy, done
    );

    modport master (
        output start, num_samples, sample_stb, pbits, res_ready,
        input  res_valid, res_data, res_idx, res_last, busy, done
    );
endinterface

// File: rtl/pbit_marginal_accumulator.sv
// Counts, per p-bit, the sweeps with m_i = 1 over a run of N samples after a burn-in,
// then streams the per-bit counts out one word per accepted handshake.
module pbit_marginal_accumulator #(
    parameter int NUM_PBITS = 9,
    parameter int CNT_W     = 16,
    parameter int BURN_IN   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    pbit_marginal_accumulator_if.slave bus,
    output logic [1:0]                dbg_state
);
    localparam int IDX_W = (NUM_PBITS > 1) ? $clog2(NUM_PBITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PBITS - 1);
    localparam logic [CNT_W-1:0] BURN_LIM = CNT_W'(BURN_IN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURN  = 2'd1,
        ACCUM = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count     [NUM_PBITS];
    logic [CNT_W-1:0] count_nxt [NUM_PBITS];
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] burn_cnt;
    logic             res_valid;
    logic [CNT_W-1:0] res_data;
    logic [IDX_W-1:0] res_idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             res_last;
    logic             busy;
    logic             done;

    // Saturating add keeps a marginal pinned at full scale rather than wrapping to zero.
    always_comb begin
        for (int i = 0; i < NUM_PBITS; i++) begin
            count_nxt[i] = count[i];
            if (bus.pbits[i] && (count[i] != '1)) begin
                count_nxt[i] = count[i] + CNT_W'(1);
            end
        end
    end

    assign idx_nxt = res_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            for (int i = 0; i < NUM_PBITS; i++) begin
                count[i] <= '0;
            end
            n_lat      <= '0;
            sample_cnt <= '0;
            burn_cnt   <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_idx    <= '0;
            res_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_lat      <= bus.num_samples;
                        sample_cnt <= '0;
                        burn_cnt   <= '0;
                        busy       <= 1'b1;
                        for (int i = 0; i < NUM_PBITS; i++) begin
                            count[i] <= '0;
                        end
                        if (bus.num_samples == '0) begin
                            state     <= DRAIN;
                            res_valid <= 1'b1;
                            res_data  <= '0;
                            res_idx   <= '0;
                            res_last  <= (LAST_IDX == '0);
                        end else if (BURN_IN > 0) begin
                            state <= BURN;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                BURN: begin
                    if (bus.sample_stb) begin
                        burn_cnt <= burn_cnt + CNT_W'(1);
                        if (burn_cnt + CNT_W'(1) == BURN_LIM) begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.sample_stb) begin
                        count      <= count_nxt;
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        // The completing strobe also loads word 0 so it appears one cycle later.
                        if (sample_cnt + CNT_W'(1) == n_lat) begin
                            state     <= DRAIN;
                            res_valid <= 1'b1;
                            res_data  <= count_nxt[0];
                            res_idx   <= '0;
                            res_last  <= (LAST_IDX == '0);
                        end
                    end
                end
                DRAIN: begin
                    if (bus.res_ready) begin
                        if (res_last) begin
                            state     <= IDLE;
                            res_valid <= 1'b0;
                            res_data  <= '0;
                            res_idx   <= '0;
                            res_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            res_idx  <= idx_nxt;
                            res_data <= count[idx_nxt];
                            res_last <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_idx   = res_idx;
    assign bus.res_last  = res_last;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign dbg_state     = state;
endmodule
